// File: rtl/conv_arbiter_pkg.sv
// Shared types and field widths for the converter arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_arbiter_pkg;

    localparam int IN_W  = 24;
    localparam int OUT_W = 16;
    localparam int EXP_W = 5;
    localparam int MAN_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/sint24_to_bf16.sv
// Signed 24-bit integer to 16-bit {sign, exp, man} float; mantissa truncated.
// Latency: combinational.
// Backpressure: none, pure function of in_val.
module sint24_to_bf16
    import conv_arbiter_pkg::*;
(
    input  logic [IN_W-1:0]  in_val,
    output logic [OUT_W-1:0] out_val
);

    logic [IN_W-1:0]  mag;
    logic [EXP_W-1:0] msb;
    logic [IN_W-1:0]  norm;

    always_comb begin
        // -0x800000 wraps back to 0x800000, which is the correct magnitude
        mag = in_val[IN_W-1] ? (-in_val) : in_val;
        msb = '0;
        for (int i = 0; i < IN_W; i++) begin
            if (mag[i]) begin
                msb = EXP_W'(i);
            end
        end
        norm    = mag << (EXP_W'(IN_W-1) - msb);
        out_val = '0;
        if (mag != '0) begin
            out_val = {in_val[IN_W-1], msb + EXP_W'(1), norm[IN_W-2 -: MAN_W]};
        end
    end

endmodule

// File: rtl/conv_arbiter.sv
// Round-robin arbiter sharing one int-to-float converter among N_REQ requesters.
// Latency: accept cycle T, out_valid from cycle T+2; one transaction in flight.
// Backpressure: out_valid/out_data held while out_ready low; no grants until handshake.
module conv_arbiter
    import conv_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int TAG_W = 2
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [IN_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  out_valid,
    output logic [OUT_W-1:0]      out_data,
    output logic [TAG_W-1:0]      out_tag,
    input  logic                  out_ready,
    output logic [15:0]           conv_count,
    output logic                  busy
);

    state_t            state, state_nxt;
    logic [TAG_W-1:0]  rr_ptr;
    logic [TAG_W-1:0]  win_tag;
    logic              win_any;
    logic [TAG_W:0]    rr_sum;
    logic [TAG_W-1:0]  rr_idx;
    logic [IN_W-1:0]   in_reg;
    logic [TAG_W-1:0]  in_tag;
    logic [OUT_W-1:0]  conv_val;
    logic [15:0]       conv_count_q;
    logic              accept, load_out, hs;

    // Scan downward from the farthest offset so the closest set bit at/after rr_ptr wins.
    always_comb begin
        win_any = 1'b0;
        win_tag = '0;
        rr_sum  = '0;
        rr_idx  = '0;
        for (int k = N_REQ-1; k >= 0; k--) begin
            rr_sum = {1'b0, rr_ptr} + (TAG_W+1)'(k);
            if (rr_sum >= (TAG_W+1)'(N_REQ)) begin
                rr_sum = rr_sum - (TAG_W+1)'(N_REQ);
            end
            rr_idx = rr_sum[TAG_W-1:0];
            if (req_valid[rr_idx]) begin
                win_any = 1'b1;
                win_tag = rr_idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        load_out  = 1'b0;
        hs        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_any && !rst) begin
                    req_ready[win_tag] = 1'b1;
                    accept             = 1'b1;
                    state_nxt          = ST_CONV;
                end
            end
            ST_CONV: begin
                load_out  = 1'b1;
                state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_valid && out_ready) begin
                    hs        = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr       <= '0;
            in_reg       <= '0;
            in_tag       <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_tag      <= '0;
            conv_count_q <= '0;
        end else begin
            if (accept) begin
                in_reg <= req_data[win_tag*IN_W +: IN_W];
                in_tag <= win_tag;
                rr_ptr <= (win_tag == TAG_W'(N_REQ-1)) ? '0 : win_tag + TAG_W'(1);
            end
            if (load_out) begin
                out_data  <= conv_val;
                out_tag   <= in_tag;
                out_valid <= 1'b1;
            end
            if (hs) begin
                out_valid    <= 1'b0;
                conv_count_q <= conv_count_q + 16'd1;
            end
        end
    end

    sint24_to_bf16 u_conv (
        .in_val  (in_reg),
        .out_val (conv_val)
    );

    assign conv_count = conv_count_q;
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_conv_arbiter.sv
// Scoreboard bench for conv_arbiter: grants push model results, output handshakes pop them.
module tb_conv_arbiter;

    localparam int N_REQ = 4;
    localparam int TAG_W = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [24*N_REQ-1:0]  req_data;
    logic [N_REQ-1:0]     req_ready;
    logic                 out_valid;
    logic [15:0]          out_data;
    logic [TAG_W-1:0]     out_tag;
    logic                 out_ready;
    logic [15:0]          conv_count;
    logic                 busy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [17:0] sb[$];
    logic        drop_on_grant;
    logic [N_REQ-1:0] pend_drop;
    int          gnt;
    logic        hs;

    always #5 clk = ~clk;

    conv_arbiter #(.N_REQ(N_REQ), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .out_ready  (out_ready),
        .conv_count (conv_count),
        .busy       (busy)
    );

    // Reference conversion done arithmetically on wide integers.
    function automatic logic [15:0] model(input logic [23:0] v);
        longint mag;
        int     m;
        logic [9:0] man;
        if (v[23]) mag = 64'h1000000 - longint'(v);
        else       mag = longint'(v);
        if (mag == 0) return 16'h0000;
        m = 0;
        while ((mag >> (m + 1)) != 0) m++;
        man = 10'((mag << 10) >> m);
        return {v[23], 5'(m + 1), man};
    endfunction

    function automatic logic [17:0] sb_next();
        if (sb.size() == 0) return 18'h3FFFF;
        return sb.pop_front();
    endfunction

    task automatic set_req(input int i, input logic [23:0] d);
        req_data[24*i +: 24] = d;
        req_valid[i] = 1'b1;
    endtask

    task automatic to_edge();
        @(posedge clk);
        #1;
        if (drop_on_grant) req_valid = req_valid & ~pend_drop;
        pend_drop = '0;
    endtask

    task automatic sample();
        @(negedge clk);
        gnt = -1;
        for (int i = 0; i < N_REQ; i++) if (req_ready[i]) gnt = i;
        if (gnt >= 0) begin
            pend_drop[gnt] = 1'b1;
            sb.push_back({2'(gnt), model(req_data[24*gnt +: 24])});
        end
        hs = out_valid && out_ready;
    endtask

    task automatic advance();
        to_edge();
        sample();
    endtask

    task automatic drain();
        to_edge();
        req_valid = '0;
        drop_on_grant = 1'b1;
        sample();
        for (int i = 0; i < 4; i++) advance();
        sb.delete();
    endtask

    task automatic test_reset();
        to_edge(); rst = 1'b1; req_valid = '1; sample();
        n_cmp++;
        if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        advance();
        n_cmp++;
        if ({out_valid, out_data, out_tag, conv_count, busy} !== 36'd0) begin
            n_err++;
            $display("FAIL reset_state: valid=%b data=%h tag=%0d count=%h busy=%b want all zero",
                     out_valid, out_data, out_tag, conv_count, busy);
        end
        to_edge(); rst = 1'b0; req_valid = '0; sb.delete(); sample();
    endtask

    task automatic test_single();
        logic [17:0] e;
        to_edge(); out_ready = 1'b1; set_req(0, 24'h000003); sample();
        n_cmp++;
        if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b want 0001", req_ready); end
        advance();
        n_cmp++;
        if ({out_valid, busy, req_ready} !== 6'b010000) begin
            n_err++; $display("FAIL single_conv: valid=%b busy=%b ready=%b want 0 1 0000", out_valid, busy, req_ready);
        end
        advance();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 16'h0A00 || out_tag !== 2'd0) begin
            n_err++; $display("FAIL single_out: valid=%b data=%h tag=%0d want 1 0a00 0", out_valid, out_data, out_tag);
        end
        e = sb_next();
        n_cmp++;
        if ({out_tag, out_data} !== e) begin n_err++; $display("FAIL single_sb: got %h want %h", {out_tag, out_data}, e); end
        advance();
        n_cmp++;
        if (conv_count !== 16'd1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL single_count: count=%h valid=%b want 0001 0", conv_count, out_valid);
        end
    endtask

    task automatic test_extremes();
        logic [23:0] vals [5];
        logic [15:0] exps [5];
        logic [17:0] e;
        logic        done;
        vals = '{24'hFFFFFF, 24'h800000, 24'h7FFFFF, 24'h000000, 24'h000001};
        exps = '{16'h8400, 16'hE000, 16'h5FFF, 16'h0000, 16'h0400};
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            to_edge(); set_req(0, vals[k]); sample();
            done = 1'b0;
            for (int c = 0; c < 8 && !done; c++) begin
                if (hs) begin
                    e = sb_next();
                    n_cmp++;
                    if (out_data !== exps[k]) begin
                        n_err++; $display("FAIL extreme_%0d: in=%h got %h want %h", k, vals[k], out_data, exps[k]);
                    end
                    n_cmp++;
                    if (out_tag !== e[17:16]) begin n_err++; $display("FAIL extreme_tag_%0d: got %0d want %0d", k, out_tag, e[17:16]); end
                    done = 1'b1;
                end
                advance();
            end
            if (!done) begin n_cmp++; n_err++; $display("FAIL extreme_timeout_%0d: no output handshake", k); end
        end
    endtask

    task automatic test_fairness();
        logic [17:0] e;
        int ng, last;
        to_edge(); rst = 1'b1; sample();
        to_edge(); rst = 1'b0; sb.delete();
        drop_on_grant = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < N_REQ; i++) set_req(i, 24'($urandom));
        sample();
        ng = 0; last = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            if (gnt >= 0) begin
                n_cmp++;
                if (gnt !== ng % 4) begin n_err++; $display("FAIL fair_order_%0d: got %0d want %0d", ng, gnt, ng % 4); end
                if (ng > 0) begin
                    n_cmp++;
                    if (c - last !== 3) begin n_err++; $display("FAIL fair_spacing_%0d: got %0d want 3", ng, c - last); end
                end
                last = c; ng++;
            end
            if (hs) begin
                e = sb_next();
                n_cmp++;
                if ({out_tag, out_data} !== e) begin n_err++; $display("FAIL fair_out: got %h want %h", {out_tag, out_data}, e); end
            end
            advance();
        end
        if (ng < 6) begin n_cmp++; n_err++; $display("FAIL fair_timeout: got %0d grants want 6", ng); end
        drain();
    endtask

    task automatic test_backpressure();
        logic [15:0] hold_d, cnt0;
        logic [1:0]  hold_t;
        logic [17:0] e;
        to_edge(); out_ready = 1'b0; set_req(0, 24'hABCDEF); sample();
        advance(); advance();
        n_cmp++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid: got %b want 1", out_valid); end
        hold_d = out_data; hold_t = out_tag; cnt0 = conv_count;
        to_edge(); set_req(3, 24'h000123); sample();
        for (int c = 0; c < 10; c++) begin
            n_cmp++;
            if ({out_valid, out_data, out_tag, req_ready, conv_count} !== {1'b1, hold_d, hold_t, 4'b0000, cnt0}) begin
                n_err++;
                $display("FAIL bp_hold_%0d: valid=%b data=%h tag=%0d ready=%b count=%h want 1 %h %0d 0000 %h",
                         c, out_valid, out_data, out_tag, req_ready, conv_count, hold_d, hold_t, cnt0);
            end
            advance();
        end
        to_edge(); req_valid = '0; out_ready = 1'b1; sample();
        e = sb_next();
        n_cmp++;
        if (!hs || {out_tag, out_data} !== e) begin
            n_err++; $display("FAIL bp_release: hs=%b got %h want %h", hs, {out_tag, out_data}, e);
        end
        to_edge(); out_ready = 1'b0; sample();
        n_cmp++;
        if (conv_count !== 16'(cnt0 + 1) || out_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_count: count=%h valid=%b want %h 0", conv_count, out_valid, 16'(cnt0 + 1));
        end
    endtask

    task automatic test_reset_mid();
        logic [17:0] e;
        logic        done;
        to_edge(); out_ready = 1'b0; set_req(1, 24'h123456); sample();
        advance(); advance();
        to_edge(); rst = 1'b1; set_req(1, 24'h0000F0); set_req(2, 24'hF00000); sample();
        n_cmp++;
        if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rstmid_ready: got %b want 0000", req_ready); end
        to_edge(); rst = 1'b0; sb.delete(); sample();
        n_cmp++;
        if ({out_valid, conv_count, req_ready} !== {1'b0, 16'h0000, 4'b0010}) begin
            n_err++; $display("FAIL rstmid_state: valid=%b count=%h ready=%b want 0 0000 0010", out_valid, conv_count, req_ready);
        end
        to_edge(); out_ready = 1'b1; sample();
        done = 1'b0;
        for (int c = 0; c < 8 && !done; c++) begin
            if (hs) begin
                e = sb_next();
                n_cmp++;
                if ({out_tag, out_data} !== e || out_tag !== 2'd1) begin
                    n_err++; $display("FAIL rstmid_out: got %h want %h (tag 1)", {out_tag, out_data}, e);
                end
                done = 1'b1;
            end
            advance();
        end
        if (!done) begin n_cmp++; n_err++; $display("FAIL rstmid_timeout: no output handshake"); end
        drain();
    endtask

    task automatic test_random();
        logic [17:0] e;
        logic        done;
        out_ready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            to_edge();
            for (int i = 0; i < N_REQ; i++) if ($urandom_range(0, 1) == 1) set_req(i, 24'($urandom));
            set_req(r, 24'($urandom));
            sample();
            done = 1'b0;
            for (int c = 0; c < 60 && !done; c++) begin
                if (hs) begin
                    e = sb_next();
                    n_cmp++;
                    if ({out_tag, out_data} !== e) begin n_err++; $display("FAIL random_%0d: got %h want %h", r, {out_tag, out_data}, e); end
                end
                if (req_valid == '0 && sb.size() == 0) done = 1'b1;
                else advance();
            end
            if (!done) begin n_cmp++; n_err++; $display("FAIL random_timeout_%0d: %0d results pending", r, sb.size()); end
        end
    endtask

    task automatic test_wrap();
        logic done;
        drain();
        force dut.conv_count_q = 16'hFFFF;
        to_edge(); release dut.conv_count_q; sample();
        n_cmp++;
        if (conv_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_preload: got %h want ffff", conv_count); end
        to_edge(); out_ready = 1'b1; set_req(3, 24'h000040); sample();
        done = 1'b0;
        for (int c = 0; c < 8 && !done; c++) begin
            if (hs) done = 1'b1;
            advance();
        end
        n_cmp++;
        if (!done || conv_count !== 16'h0000) begin
            n_err++; $display("FAIL wrap_count: hs=%b got %h want 0000", done, conv_count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        out_ready = 1'b0;
        drop_on_grant = 1'b1;
        pend_drop = '0;
        gnt = -1;
        hs = 1'b0;
        test_reset();
        test_single();
        test_extremes();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
